alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Front-end controller for the team's ALU datapath: accepts one MIPS-funct-coded operation at a time over a valid/ready request channel and decodes it to the 3-bit ALU control. Single-cycle logic/arithmetic ops are dispatched to the external combinational ALU. MULTU is run internally as a 32-iteration shift-add sequence into Hi/Lo, and MFHI/MFLO read those registers. Results return over a valid/ready response channel, so a CPU stage or the bench can drive the ALU without hand-timing the multiply window.

## Interface
Parameters:
- MUL_ITERS, 32, shift-add iterations for MULTU; must equal operand width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_funct  in  6  operation: 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 25 MULTU, 16 MFHI, 18 MFLO
- req_a, req_b  in  32  operands (dataA, dataB)
- alu_ctrl  out  3  to ALU: AND 000, OR 001, ADD 010, SUB 110, SLT 111
- alu_a, alu_b  out  32  registered operands to ALU
- alu_y  in  32  combinational ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  32  result
- rsp_err  out  1  unsupported funct
- hi, lo  out  32  Hi/Lo register contents
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, EXEC, MUL, RESP.
- IDLE: req_ready=1. A request is accepted on an edge with req_valid=1.
  - ALU funct: latch alu_ctrl/alu_a/alu_b and go to EXEC.
  - 25: set Hi=0, Lo=req_b, latch multiplicand M=req_a, clear counter, go to MUL.
  - 16/18: load rsp_data=hi/lo, go to RESP.
  - Any other funct: rsp_data=0, rsp_err=1, go to RESP.
- EXEC: one cycle. Capture rsp_data=alu_y and rsp_err=0, then go to RESP.
- MUL: each cycle compute s = {1'b0,Hi} + (Lo[0] ? {1'b0,M} : 0), 33 bits, then {Hi,Lo} <= {s, Lo[31:1]}.
  - The counter increments each cycle. When the counter reaches MUL_ITERS-1, the update for that cycle completes, rsp_data=final Lo, rsp_err=0, and the state goes to RESP.
  - The result is an unsigned 64-bit product {Hi,Lo}, with no overflow flag.
- RESP: rsp_valid=1. rsp_data and rsp_err hold stable until an edge with rsp_ready=1, then the state goes to IDLE. A new request is not accepted on that same edge.
- alu_ctrl/alu_a/alu_b change only when an ALU funct is accepted. They hold otherwise.
- Hi/Lo change only during MULTU. They persist across all other ops, so MFHI/MFLO return the last product.
- Reset values: state IDLE, req_ready=1 once reset is released, rsp_valid=0, rsp_data=0, rsp_err=0, alu_ctrl=000, alu_a=alu_b=0, hi=lo=0, counter 0, busy=0.
- Reset asserted mid-MUL or in RESP: the operation is abandoned, with no response and Hi/Lo cleared.

## Timing
- Accept on edge N.
- ALU op: alu_* valid during cycle N+1, captured at edge N+1, rsp_valid high from cycle N+2.
- MULTU: iterations on edges N+1..N+32, rsp_valid high from cycle N+33. Hi/Lo are final from cycle N+33.
- MFHI/MFLO/illegal: rsp_valid high from cycle N+1.
- Minimum spacing between accepts is 1 cycle of IDLE after the response handshake edge. Throughput is at most one op per 3 cycles for ALU ops.
- req_* values outside an accept edge are ignored. Operands must be stable only on the accept edge.

## Test plan
- ADD 5, 7 with an ALU model: alu_ctrl=010 in cycle N+1; rsp_valid in cycle N+2 with rsp_data=12, rsp_err=0. Repeat SUB 3−5 → 0xFFFFFFFE, SLT 3,5 → 1, AND/OR 0xF0F0,0x0FF0 → 0x00F0/0xFFF0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF: busy for 32 cycles, rsp_valid in cycle N+33. Then MFHI → 0xFFFFFFFE and MFLO → 0x00000001, each responding 1 cycle after accept.
- MULTU 123456×0 → hi=lo=0. MULTU 1×0x80000000 → hi=0, lo=0x80000000.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. rsp_data stays constant, req_ready stays 0, and a req_valid pulse is not accepted.
- funct 3 → rsp_err=1, rsp_data=0 one cycle later. alu_ctrl, hi and lo are unchanged.
- Pull reset low at iteration 10 of a MULTU. Outputs immediately take reset values, no rsp_valid appears, and a following ADD works normally.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-side signal bundle for alu_op_sequencer.
// The slave modport is the sequencer; the master modport is the CPU stage or bench driving it.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport slave (
    input  req_valid, req_funct, req_a, req_b, alu_y, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, hi, lo, busy
  );

  modport master (
    output req_valid, req_funct, req_a, req_b, alu_y, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, hi, lo, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the ALU datapath: decodes MIPS funct codes, dispatches
// single-cycle ops to the external ALU and runs MULTU as a shift-add loop into Hi/Lo.
module alu_op_sequencer #(
  parameter int MUL_ITERS = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_sequencer_if.slave  bus
);
  localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(MUL_ITERS - 1);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   hi_reg, lo_reg, m_reg;
  logic [31:0]   alu_a_reg, alu_b_reg, rsp_data_reg;
  logic [2:0]    alu_ctrl_reg;
  logic          rsp_err_reg;
  logic [CW-1:0] cnt_reg;

  logic          accept;
  logic          alu_op;
  logic [2:0]    dec_ctrl;
  logic [32:0]   sum;
  logic          mul_last;

  always_comb begin
    dec_ctrl = 3'b000;
    alu_op   = 1'b1;
    case (bus.req_funct)
      F_AND:   dec_ctrl = 3'b000;
      F_OR:    dec_ctrl = 3'b001;
      F_ADD:   dec_ctrl = 3'b010;
      F_SUB:   dec_ctrl = 3'b110;
      F_SLT:   dec_ctrl = 3'b111;
      default: alu_op   = 1'b0;
    endcase
  end

  assign accept   = (state_reg == IDLE) && bus.req_valid;
  // One shift-add step: conditionally add the multiplicand to Hi, carry goes into the shift.
  assign sum      = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : 33'd0);
  assign mul_last = (cnt_reg == LAST_ITER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (alu_op)                       state_next = EXEC;
          else if (bus.req_funct == F_MULTU) state_next = MUL;
          else                              state_next = RESP;
        end
      end
      EXEC:    state_next = RESP;
      MUL:     if (mul_last) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg       <= '0;
      lo_reg       <= '0;
      m_reg        <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_ctrl_reg <= 3'b000;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (alu_op) begin
              alu_ctrl_reg <= dec_ctrl;
              alu_a_reg    <= bus.req_a;
              alu_b_reg    <= bus.req_b;
            end else if (bus.req_funct == F_MULTU) begin
              hi_reg  <= '0;
              lo_reg  <= bus.req_b;
              m_reg   <= bus.req_a;
              cnt_reg <= '0;
            end else if (bus.req_funct == F_MFHI) begin
              rsp_data_reg <= hi_reg;
              rsp_err_reg  <= 1'b0;
            end else if (bus.req_funct == F_MFLO) begin
              rsp_data_reg <= lo_reg;
              rsp_err_reg  <= 1'b0;
            end else begin
              rsp_data_reg <= '0;
              rsp_err_reg  <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_data_reg <= bus.alu_y;
          rsp_err_reg  <= 1'b0;
        end
        MUL: begin
          hi_reg  <= sum[32:1];
          lo_reg  <= {sum[0], lo_reg[31:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (mul_last) begin
            rsp_data_reg <= {sum[0], lo_reg[31:1]};
            rsp_err_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.alu_ctrl  = alu_ctrl_reg;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the alu_* side.
// Drives inputs just after rising edges and samples outputs on falling edges.
module tb_alu_op_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   lat;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.MUL_ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_ctrl)
      3'b000:  bus.alu_y = bus.alu_a & bus.alu_b;
      3'b001:  bus.alu_y = bus.alu_a | bus.alu_b;
      3'b010:  bus.alu_y = bus.alu_a + bus.alu_b;
      3'b110:  bus.alu_y = bus.alu_a - bus.alu_b;
      3'b111:  bus.alu_y = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_y = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_funct = 6'd63;
    bus.req_a     = 32'h5A5A_5A5A;
    bus.req_b     = 32'hA5A5_A5A5;
  endtask

  // Returns the cycle (relative to the accept edge) in which rsp_valid is first seen.
  task automatic wait_rsp(input string tag, output int cyc);
    @(negedge clk);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.rsp_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] exp_ctrl,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int cyc;
    issue(f, a, b);
    @(negedge clk);
    check({tag, "_ctrl"}, 32'(bus.alu_ctrl), 32'(exp_ctrl));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"},  32'(cyc), 32'(exp_lat));
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_err"},  32'(bus.rsp_err), 32'(exp_err));
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_funct = 6'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  bus.rsp_data, 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("rst_alu_ctrl",  32'(bus.alu_ctrl), 32'd0);
    check("rst_hi",        bus.hi, 32'd0);
    check("rst_lo",        bus.lo, 32'd0);
    check("rst_busy",      32'(bus.busy), 32'd0);

    do_op("add", 6'd32, 32'd5,      32'd7,      3'b010, 32'd12,         1'b0, 2);
    do_op("sub", 6'd34, 32'd3,      32'd5,      3'b110, 32'hFFFF_FFFE,  1'b0, 2);
    do_op("slt", 6'd42, 32'd3,      32'd5,      3'b111, 32'd1,          1'b0, 2);
    do_op("and", 6'd36, 32'hF0F0,   32'h0FF0,   3'b000, 32'h0000_00F0,  1'b0, 2);
    do_op("or",  6'd37, 32'hF0F0,   32'h0FF0,   3'b001, 32'h0000_FFF0,  1'b0, 2);

    do_op("mul_ff", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 32'h0000_0001, 1'b0, 33);
    check("mul_ff_hi", bus.hi, 32'hFFFF_FFFE);
    check("mul_ff_lo", bus.lo, 32'h0000_0001);
    do_op("mfhi", 6'd16, 32'd0, 32'd0, 3'b001, 32'hFFFF_FFFE, 1'b0, 1);
    do_op("mflo", 6'd18, 32'd0, 32'd0, 3'b001, 32'h0000_0001, 1'b0, 1);

    do_op("illegal", 6'd3, 32'd9, 32'd9, 3'b001, 32'd0, 1'b1, 1);
    check("illegal_hi", bus.hi, 32'hFFFF_FFFE);
    check("illegal_lo", bus.lo, 32'h0000_0001);

    do_op("mul_zero", 6'd25, 32'd123456, 32'd0, 3'b001, 32'd0, 1'b0, 33);
    check("mul_zero_hi", bus.hi, 32'd0);
    check("mul_zero_lo", bus.lo, 32'd0);
    do_op("mul_msb", 6'd25, 32'd1, 32'h8000_0000, 3'b001, 32'h8000_0000, 1'b0, 33);
    check("mul_msb_hi", bus.hi, 32'd0);
    check("mul_msb_lo", bus.lo, 32'h8000_0000);

    // Backpressure: response must hold and a stray request must be ignored.
    issue(6'd32, 32'd10, 32'd20);
    wait_rsp("bp", lat);
    check("bp_lat",  32'(lat), 32'd2);
    check("bp_data", bus.rsp_data, 32'd30);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd32;
        bus.req_a     = 32'd1;
        bus.req_b     = 32'd1;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("bp_hold_data",  bus.rsp_data, 32'd30);
      check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
    end
    check("bp_alu_a", bus.alu_a, 32'd10);
    // A request present on the handshake edge must not be taken.
    bus.req_valid = 1'b1;
    bus.req_funct = 6'd16;
    handshake();
    @(negedge clk);
    check("hs_no_accept_ready", 32'(bus.req_ready), 32'd1);
    check("hs_no_accept_valid", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 1'b0;

    // Abandon a MULTU at iteration 10 via asynchronous reset.
    issue(6'd25, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #2;
    check("mid_mul_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_busy",      32'(bus.busy), 32'd0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_hi",        bus.hi, 32'd0);
    check("arst_lo",        bus.lo, 32'd0);
    check("arst_alu_ctrl",  32'(bus.alu_ctrl), 32'd0);
    check("arst_alu_a",     bus.alu_a, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    do_op("add_after_rst", 6'd32, 32'd100, 32'd23, 3'b010, 32'd123, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
